instr_fetch_unit: RTL

Instruction fetch front end that supplies instruction words, and their opcode fields, to the main control decoder and the rest of decode. It is the producer end of the opcode/control path: it holds the PC and issues requests to instruction memory. It also consumes the redirect produced when the control unit's Branch, Jump and JumpReg resolve in execute. At most one memory request is outstanding, there is a one-entry output buffer, and in-flight fetches are squashed on redirect.

---
 rtl/instr_fetch_unit.sv | 121 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, keeps at most one instruction
// memory request in flight, buffers one instruction for decode, and squashes
// in-flight work when execute redirects the PC.
module instr_fetch_unit #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    // instruction memory request/response
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    // decode side
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [6:0]      if_opcode,
    // redirect from execute
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam logic [1:0] S_REQ  = 2'd0;  // request presented to memory
    localparam logic [1:0] S_WAIT = 2'd1;  // request accepted, awaiting data
    localparam logic [1:0] S_HOLD = 2'd2;  // instruction offered to decode
    localparam logic [1:0] S_DROP = 2'd3;  // awaiting a response that is discarded

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_if_instr;
    logic [XLEN-1:0] r_if_pc;

    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pc_inc;
    logic            w_capture;

    // Redirect targets are forced to word alignment; PC increment wraps naturally.
    assign w_target = redirect_pc & ~XLEN'(3);
    assign w_pc_inc = r_pc + XLEN'(4);

    // A response is only kept when it answers a live request and no redirect
    // squashes it in the same cycle.
    assign w_capture = (r_state == S_WAIT) & imem_rsp_valid & ~redirect_valid;

    // Requests are suppressed during reset; the address always mirrors the PC.
    assign imem_req_valid = (r_state == S_REQ) & ~rst;
    assign imem_req_addr  = r_pc;

    // A redirect masks the buffered instruction so decode never takes a
    // squashed word, even when it is ready in the same cycle.
    assign if_valid  = (r_state == S_HOLD) & ~redirect_valid;
    assign if_instr  = r_if_instr;
    assign if_pc     = r_if_pc;
    assign if_opcode = r_if_instr[6:0];

    // Fetch FSM and PC; redirect takes priority over every other transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (redirect_valid) begin
                        r_pc <= w_target;
                        // An accepted request still owes a response that must be eaten.
                        r_state <= imem_req_ready ? S_DROP : S_REQ;
                    end else if (imem_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        r_pc    <= w_target;
                        r_state <= imem_rsp_valid ? S_REQ : S_DROP;
                    end else if (imem_rsp_valid) begin
                        r_pc    <= w_pc_inc;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        r_pc    <= w_target;
                        r_state <= S_REQ;
                    end else if (if_ready) begin
                        r_state <= S_REQ;
                    end
                end
                default: begin  // S_DROP
                    if (redirect_valid) begin
                        r_pc <= w_target;
                    end
                    // The stale response retires the outstanding request even when
                    // a redirect lands in the same cycle; staying here would wait
                    // for a response that never comes.
                    if (imem_rsp_valid) begin
                        r_state <= S_REQ;
                    end
                end
            endcase
        end
    end

    // One-entry output buffer: changes only on capture or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_instr <= NOP_INSTR;
            r_if_pc    <= RESET_PC;
        end else if (w_capture) begin
            r_if_instr <= imem_rsp_data;
            r_if_pc    <= r_pc;
        end
    end

endmodule
